// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port
// between instruction fetch and load/store, one transaction at a time.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LS_MAX     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [3:0]            i_ls_be,
  input  logic [ADDR_WIDTH-1:0] i_ls_addr,
  input  logic [DATA_WIDTH-1:0] i_ls_wdata,
  output logic                  o_ls_gnt,
  output logic                  o_ls_rvalid,
  output logic [DATA_WIDTH-1:0] o_ls_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IF   = 2'd1,
    S_LS   = 2'd2
  } state_t;

  localparam logic [1:0] LS_LIM = 2'(LS_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_streak;
  logic       w_ls_win;
  logic       w_if_win;
  logic       w_if_done;
  logic       w_ls_done;

  logic                  r_if_rvalid;
  logic                  r_ls_rvalid;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_ls_rdata;
  logic                  r_mem_we;
  logic [3:0]            r_mem_be;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Arbitration in IDLE; wait for ack while busy
  always_comb begin
    w_next   = r_state;
    w_ls_win = 1'b0;
    w_if_win = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ls_win = i_ls_req &&
                   !(i_if_req && r_streak == LS_LIM);
        w_if_win = i_if_req && !w_ls_win;
        if (w_ls_win)      w_next = S_LS;
        else if (w_if_win) w_next = S_IF;
      end
      S_IF, S_LS: begin
        if (i_mem_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_if_done = (r_state == S_IF) && i_mem_ack;
  assign w_ls_done = (r_state == S_LS) && i_mem_ack;

  // Consecutive LS wins while IF waits; forces IF through at the limit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak <= 2'd0;
    end else if (w_ls_win) begin
      if (!i_if_req)               r_streak <= 2'd0;
      else if (r_streak != 2'd3)   r_streak <= r_streak + 2'd1;
    end else if (w_if_win) begin
      r_streak <= 2'd0;
    end
  end

  // Memory payload, latched on grant and frozen until the next one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_ls_win) begin
      r_mem_we    <= i_ls_we;
      r_mem_be    <= i_ls_be;
      r_mem_addr  <= i_ls_addr;
      r_mem_wdata <= i_ls_wdata;
    end else if (w_if_win) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'hF;
      r_mem_addr  <= i_if_addr;
      r_mem_wdata <= '0;
    end
  end

  // Completion: capture data for the owner and pulse its rvalid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_if_done;
      r_ls_rvalid <= w_ls_done;
      if (w_if_done) r_if_rdata <= i_mem_rdata;
      if (w_ls_done) r_ls_rdata <= i_mem_rdata;
    end
  end

  assign o_if_gnt    = w_if_win;
  assign o_ls_gnt    = w_ls_win;
  assign o_if_rvalid = r_if_rvalid;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_req   = (r_state != S_IDLE);
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the shared port.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LS_MAX = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_pass = 0;
  int n_total = 0;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LS_MAX(LS_MAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid),
    .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be),
    .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid),
    .o_ls_rdata(ls_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    #1;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_be = '0;
    ls_addr = '0; ls_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [DW*2+AW*2+16-1:0] flat;
    apply_reset;
    for (int c = 0; c < 10; c++) begin
      mem_ack = (c == 4);
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      flat = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid,
              ls_rdata, mem_req, mem_we, mem_be, mem_addr,
              mem_wdata, busy};
      n_total++;
      if (flat !== '0)
        $display("FAIL reset_outs c=%0d got=%h want=0", c, flat);
      else n_pass++;
      step;
    end
    mem_ack = 0;
  endtask

  task automatic test_if_read;
    apply_reset;
    if_req = 1; if_addr = 32'h0000_0040;
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt} !== 2'b10)
      $display("FAIL if_gnt got=%b want=10", {if_gnt, ls_gnt});
    else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      step;
      if_req = 0;
      mem_ack = (c == 3);
      mem_rdata = (c == 3) ? 32'h2108_0004 : 32'h0;
      @(negedge clk);
      n_total++;
      if ({mem_req, mem_we, mem_be, mem_addr} !==
          {1'b1, 1'b0, 4'hF, 32'h40})
        $display("FAIL if_payload c=%0d got=%b%b%h_%h want=10f_40",
                 c, mem_req, mem_we, mem_be, mem_addr);
      else n_pass++;
    end
    step;
    mem_ack = 0;
    @(negedge clk);
    n_total++;
    if ({if_rvalid, if_rdata, mem_req, busy} !==
        {1'b1, 32'h2108_0004, 1'b0, 1'b0})
      $display("FAIL if_rvalid got=%b %h %b%b want=1 21080004 00",
               if_rvalid, if_rdata, mem_req, busy);
    else n_pass++;
    step;
    @(negedge clk);
    n_total++;
    if (if_rvalid !== 1'b0)
      $display("FAIL if_rvalid_pulse got=%b want=0", if_rvalid);
    else n_pass++;
  endtask

  task automatic test_ls_store;
    apply_reset;
    ls_req = 1; ls_we = 1; ls_be = 4'b0011;
    ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt} !== 2'b01)
      $display("FAIL ls_gnt got=%b want=01", {if_gnt, ls_gnt});
    else n_pass++;
    step;
    ls_req = 0;
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF})
      $display("FAIL ls_payload got=%b%b%h_%h_%h want=113_100_deadbeef",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    else n_pass++;
    step;
    mem_ack = 0;
    @(negedge clk);
    n_total++;
    if ({ls_rvalid, if_rvalid, ls_rdata} !== {2'b10, 32'h1234_5678})
      $display("FAIL ls_rvalid got=%b%b %h want=10 12345678",
               ls_rvalid, if_rvalid, ls_rdata);
    else n_pass++;
  endtask

  task automatic test_starvation;
    logic [1:0] want;
    apply_reset;
    if_req = 1; if_addr = 32'h200;
    ls_req = 1; ls_addr = 32'h300; ls_we = 0; ls_be = 4'hF;
    mem_ack = 1; mem_rdata = 32'h55;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      want = (g % (LS_MAX + 1) == LS_MAX) ? 2'b10 : 2'b01;
      n_total++;
      if ({if_gnt, ls_gnt} !== want)
        $display("FAIL starve_gnt g=%0d got=%b want=%b",
                 g, {if_gnt, ls_gnt}, want);
      else n_pass++;
      step;
      step;
    end
    if_req = 0; ls_req = 0; mem_ack = 0;
    step;
  endtask

  task automatic test_no_contention;
    logic [1:0] want;
    apply_reset;
    mem_ack = 1;
    ls_req = 1; ls_addr = 32'h400;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      n_total++;
      if ({if_gnt, ls_gnt} !== 2'b01)
        $display("FAIL nc_ls g=%0d got=%b want=01",
                 g, {if_gnt, ls_gnt});
      else n_pass++;
      step;
      step;
    end
    if_req = 1; if_addr = 32'h500;
    for (int g = 0; g <= LS_MAX; g++) begin
      @(negedge clk);
      want = (g == LS_MAX) ? 2'b10 : 2'b01;
      n_total++;
      if ({if_gnt, ls_gnt} !== want)
        $display("FAIL nc_streak g=%0d got=%b want=%b",
                 g, {if_gnt, ls_gnt}, want);
      else n_pass++;
      step;
      step;
    end
    ls_req = 0;
    @(negedge clk);
    n_total++;
    if ({if_gnt, ls_gnt} !== 2'b10)
      $display("FAIL nc_if_next got=%b want=10", {if_gnt, ls_gnt});
    else n_pass++;
    step;
    if_req = 0;
    step;
    mem_ack = 0;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    ls_req = 1; ls_we = 0; ls_be = 4'hF;
    ls_addr = 32'h600; ls_wdata = 32'h0;
    @(negedge clk);
    n_total++;
    if (ls_gnt !== 1'b1)
      $display("FAIL rm_gnt got=%b want=1", ls_gnt);
    else n_pass++;
    step;
    ls_req = 0;
    step;
    rst_n = 0;
    @(negedge clk);
    n_total++;
    if ({busy, mem_req, mem_addr, mem_be, ls_rvalid} !== '0)
      $display("FAIL rm_in_reset got=%b%b %h %h %b want=0",
               busy, mem_req, mem_addr, mem_be, ls_rvalid);
    else n_pass++;
    step;
    rst_n = 1;
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({ls_rvalid, ls_rdata, busy, mem_req} !== '0)
        $display("FAIL rm_late_ack c=%0d got=%b %h %b%b want=0",
                 c, ls_rvalid, ls_rdata, busy, mem_req);
      else n_pass++;
      step;
    end
    mem_ack = 0;
    if_req = 1; if_addr = 32'h700;
    @(negedge clk);
    n_total++;
    if (if_gnt !== 1'b1)
      $display("FAIL rm_if_gnt got=%b want=1", if_gnt);
    else n_pass++;
    step;
    if_req = 0;
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    step;
    mem_ack = 0;
    @(negedge clk);
    n_total++;
    if ({if_rvalid, if_rdata, ls_rvalid} !== {1'b1, 32'hCAFE_0001, 1'b0})
      $display("FAIL rm_if_done got=%b %h %b want=1 cafe0001 0",
               if_rvalid, if_rdata, ls_rvalid);
    else n_pass++;
  endtask

  task automatic test_random;
    bit            m_busy, m_own_ls, rv_if, rv_ls;
    bit            if_pend, ls_pend, exp_if, exp_ls;
    int            m_lat, m_streak;
    logic [DW-1:0] e_if_rd, e_ls_rd, e_wd;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [3:0]    e_be;
    apply_reset;
    m_busy = 0; m_own_ls = 0; rv_if = 0; rv_ls = 0;
    if_pend = 0; ls_pend = 0; m_lat = 0; m_streak = 0;
    e_if_rd = '0; e_ls_rd = '0; e_wd = '0; e_addr = '0;
    e_we = 0; e_be = '0;
    for (int c = 0; c < 500; c++) begin
      if (c > 0) step;
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1; ls_we = 1'($urandom);
        ls_be = 4'($urandom); ls_addr = $urandom;
        ls_wdata = $urandom;
      end
      if_req = if_pend;
      ls_req = ls_pend;
      mem_ack = m_busy ? (m_lat == 0) : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      @(negedge clk);
      exp_ls = !m_busy && ls_req &&
               !(if_req && m_streak == LS_MAX);
      exp_if = !m_busy && if_req && !exp_ls;
      n_total++;
      if ({if_gnt, ls_gnt} !== {exp_if, exp_ls})
        $display("FAIL rnd_gnt c=%0d got=%b want=%b",
                 c, {if_gnt, ls_gnt}, {exp_if, exp_ls});
      else n_pass++;
      n_total++;
      if ({busy, mem_req} !== {m_busy, m_busy})
        $display("FAIL rnd_busy c=%0d got=%b%b want=%b",
                 c, busy, mem_req, m_busy);
      else n_pass++;
      n_total++;
      if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !==
          {rv_if, rv_ls, e_if_rd, e_ls_rd})
        $display("FAIL rnd_resp c=%0d got=%b%b %h %h want=%b%b %h %h",
                 c, if_rvalid, ls_rvalid, if_rdata, ls_rdata,
                 rv_if, rv_ls, e_if_rd, e_ls_rd);
      else n_pass++;
      if (m_busy) begin
        n_total++;
        if ({mem_we, mem_be, mem_addr} !== {e_we, e_be, e_addr} ||
            (m_own_ls && mem_wdata !== e_wd))
          $display("FAIL rnd_payload c=%0d got=%b %h %h %h want=%b %h %h %h",
                   c, mem_we, mem_be, mem_addr, mem_wdata,
                   e_we, e_be, e_addr, e_wd);
        else n_pass++;
      end
      rv_if = 0; rv_ls = 0;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0;
          if (m_own_ls) begin rv_ls = 1; e_ls_rd = mem_rdata; end
          else begin rv_if = 1; e_if_rd = mem_rdata; end
        end else m_lat--;
      end else if (exp_ls) begin
        m_busy = 1; m_own_ls = 1; m_lat = $urandom_range(0, 3);
        e_we = ls_we; e_be = ls_be; e_addr = ls_addr; e_wd = ls_wdata;
        ls_pend = 0;
        m_streak = if_req ? ((m_streak < 3) ? m_streak + 1 : 3) : 0;
      end else if (exp_if) begin
        m_busy = 1; m_own_ls = 0; m_lat = $urandom_range(0, 3);
        e_we = 0; e_be = 4'hF; e_addr = if_addr;
        if_pend = 0;
        m_streak = 0;
      end
    end
    step;
    if_req = 0; ls_req = 0; mem_ack = 0;
  endtask

  initial begin
    rst_n = 0;
    test_reset;
    test_if_read;
    test_ls_store;
    test_starvation;
    test_no_contention;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
